// File: rtl/hsv_box_tracker.sv
// Tracks the bounding box of pixels inside an HSV window over each frame and draws the
// previous frame's box onto the RGB stream, which is delayed by two clocks.
module hsv_box_tracker #(
  parameter int          IMG_W     = 640,
  parameter int          IMG_H     = 480,
  parameter int          MIN_PIX   = 64,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pre_hs,
  input  logic        pre_vs,
  input  logic        pre_clken,
  input  logic [23:0] pre_rgb,
  input  logic [23:0] pre_hsv,
  input  logic [7:0]  h_min,
  input  logic [7:0]  h_max,
  input  logic [7:0]  s_min,
  input  logic [7:0]  s_max,
  input  logic [7:0]  v_min,
  input  logic [7:0]  v_max,
  output logic        post_hs,
  output logic        post_vs,
  output logic        post_clken,
  output logic [23:0] post_rgb,
  output logic [10:0] box_x0,
  output logic [10:0] box_x1,
  output logic [10:0] box_y0,
  output logic [10:0] box_y1,
  output logic        box_valid,
  output logic        frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LATCH} state_t;
  typedef struct packed {
    logic [7:0] h_min, h_max, s_min, s_max, v_min, v_max;
  } thr_t;

  localparam logic [10:0] COORD_MAX = '1;
  localparam logic [19:0] CNT_MAX   = '1;
  localparam logic [19:0] MIN_CNT   = 20'(MIN_PIX);
  localparam logic [11:0] X_LIM     = 12'(IMG_W);
  localparam logic [11:0] Y_LIM     = 12'(IMG_H);

  logic        hs_q, vs_q, hs_rise, hs_fall, vs_rise, vs_fall;
  state_t      state_q, state_d;
  logic        latch_en;
  logic [10:0] x_q, x_d, x_cur, y_q, y_d, y_cur;
  thr_t        thr_q, thr_in;
  logic [7:0]  h_pix, s_pix, v_pix;
  logic        hue_ok, match;
  logic [10:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [10:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [19:0] cnt_q, cnt_d;
  logic [10:0] box_x0_q, box_x1_q, box_y0_q, box_y1_q;
  logic        box_valid_q;
  logic        on_col, on_row, ovl_d;
  logic        hs1_q, vs1_q, ck1_q, ovl1_q;
  logic [23:0] rgb1_q;
  logic        hs2_q, vs2_q, ck2_q;
  logic [23:0] rgb2_q;

  // Sync copies follow the inputs even through reset, so a reset inside an active
  // frame can never be mistaken for a fresh pre_vs rise once it is released.
  // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    hs_q <= pre_hs;
    vs_q <= pre_vs;
  end

  assign hs_rise = pre_hs & ~hs_q;
  assign hs_fall = ~pre_hs & hs_q;
  assign vs_rise = pre_vs & ~vs_q;
  assign vs_fall = ~pre_vs & vs_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (vs_rise) state_d = S_ACTIVE;
      S_ACTIVE: if (vs_fall) state_d = S_LATCH;
      S_LATCH:  state_d = vs_rise ? S_ACTIVE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    latch_en   = (state_q == S_ACTIVE) && vs_fall;
    frame_done = (state_q == S_LATCH);
  end

  // The current pixel's coordinate already reflects a clear on this cycle's sync edge.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    x_cur = hs_rise ? '0 : x_q;
    y_cur = vs_rise ? '0 : y_q;
    x_d   = x_cur;
    y_d   = y_cur;
    if (pre_clken && pre_hs && x_cur != COORD_MAX) x_d = x_cur + 11'd1;
    if (hs_fall && pre_vs && y_cur != COORD_MAX)   y_d = y_cur + 11'd1;
  end

  assign thr_in = {h_min, h_max, s_min, s_max, v_min, v_max};

  always_comb begin
    {h_pix, s_pix, v_pix} = pre_hsv;
    if (thr_q.h_min <= thr_q.h_max)
      hue_ok = (h_pix >= thr_q.h_min) && (h_pix <= thr_q.h_max);
    else
      hue_ok = (h_pix >= thr_q.h_min) || (h_pix <= thr_q.h_max);
    match = pre_clken && pre_hs && pre_vs && hue_ok
         && (s_pix >= thr_q.s_min) && (s_pix <= thr_q.s_max)
         && (v_pix >= thr_q.v_min) && (v_pix <= thr_q.v_max)
         && ({1'b0, x_cur} < X_LIM) && ({1'b0, y_cur} < Y_LIM);
  end

  always_comb begin
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    if (vs_rise) begin
      min_x_d = COORD_MAX;
      max_x_d = '0;
      min_y_d = COORD_MAX;
      max_y_d = '0;
      cnt_d   = '0;
    end else if (match) begin
      if (x_cur < min_x_q) min_x_d = x_cur;
      if (x_cur > max_x_q) max_x_d = x_cur;
      if (y_cur < min_y_q) min_y_d = y_cur;
      if (y_cur > max_y_q) max_y_d = y_cur;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 20'd1;
    end
  end

  always_comb begin
    on_col = (x_cur == box_x0_q || x_cur == box_x1_q) && (y_cur >= box_y0_q) && (y_cur <= box_y1_q);
    on_row = (y_cur == box_y0_q || y_cur == box_y1_q) && (x_cur >= box_x0_q) && (x_cur <= box_x1_q);
    ovl_d  = box_valid_q && pre_clken && pre_hs && pre_vs && (on_col || on_row);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      thr_q       <= '0;
      min_x_q     <= COORD_MAX;
      max_x_q     <= '0;
      min_y_q     <= COORD_MAX;
      max_y_q     <= '0;
      cnt_q       <= '0;
      box_x0_q    <= '0;
      box_x1_q    <= '0;
      box_y0_q    <= '0;
      box_y1_q    <= '0;
      box_valid_q <= 1'b0;
      {hs1_q, vs1_q, ck1_q, ovl1_q, rgb1_q} <= '0;
      {hs2_q, vs2_q, ck2_q, rgb2_q}         <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      if (vs_rise) thr_q <= thr_in;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        if (cnt_q >= MIN_CNT) begin
          box_x0_q    <= min_x_q;
          box_x1_q    <= max_x_q;
          box_y0_q    <= min_y_q;
          box_y1_q    <= max_y_q;
          box_valid_q <= 1'b1;
        end else begin
          box_valid_q <= 1'b0;
        end
      end
      {hs1_q, vs1_q, ck1_q, ovl1_q, rgb1_q} <= {pre_hs, pre_vs, pre_clken, ovl_d, pre_rgb};
      {hs2_q, vs2_q, ck2_q} <= {hs1_q, vs1_q, ck1_q};
      rgb2_q <= ovl1_q ? BOX_COLOR : rgb1_q;
    end
  end

  assign post_hs    = hs2_q;
  assign post_vs    = vs2_q;
  assign post_clken = ck2_q;
  assign post_rgb   = rgb2_q;
  assign box_x0     = box_x0_q;
  assign box_x1     = box_x1_q;
  assign box_y0     = box_y0_q;
  assign box_y1     = box_y1_q;
  assign box_valid  = box_valid_q;

endmodule

// File: tb/tb_hsv_box_tracker.sv
// Directed bench for hsv_box_tracker: short frames of 120-pixel lines exercise the box,
// pixel-count threshold, hue wrap-around, overlay, 2-cycle latency and mid-frame reset.
module tb_hsv_box_tracker;

  localparam int          W   = 120;
  localparam int          BL  = 8;
  localparam logic [23:0] BOX = 24'hFF0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pre_hs, pre_vs, pre_clken;
  logic [23:0] pre_rgb, pre_hsv;
  logic [7:0]  h_min, h_max, s_min, s_max, v_min, v_max;
  logic        post_hs, post_vs, post_clken;
  logic [23:0] post_rgb;
  logic [10:0] box_x0, box_x1, box_y0, box_y1;
  logic        box_valid, frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  // Inputs driven one and two steps ago, used to predict the delayed outputs.
  int          h1_x = -1, h1_y = -1, h2_x = -1, h2_y = -1;
  logic        h1_hs = 1'b0, h1_vs = 1'b0, h1_ck = 1'b0;
  logic        h2_hs = 1'b0, h2_vs = 1'b0, h2_ck = 1'b0;
  logic [23:0] h1_rgb = '0, h2_rgb = '0;

  // Expected latched box.
  int   ex0 = 0, ex1 = 0, ey0 = 0, ey1 = 0;
  logic ev  = 1'b0;

  always #5 clk = ~clk;

  hsv_box_tracker dut (
    .clk        (clk),
    .rst        (rst),
    .pre_hs     (pre_hs),
    .pre_vs     (pre_vs),
    .pre_clken  (pre_clken),
    .pre_rgb    (pre_rgb),
    .pre_hsv    (pre_hsv),
    .h_min      (h_min),
    .h_max      (h_max),
    .s_min      (s_min),
    .s_max      (s_max),
    .v_min      (v_min),
    .v_max      (v_max),
    .post_hs    (post_hs),
    .post_vs    (post_vs),
    .post_clken (post_clken),
    .post_rgb   (post_rgb),
    .box_x0     (box_x0),
    .box_x1     (box_x1),
    .box_y0     (box_y0),
    .box_y1     (box_y1),
    .box_valid  (box_valid),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] rgb_of(input int x, input int y);
    return {8'(x), 8'(y), 8'h5A};
  endfunction

  // Mode 0: 10x10 block at (100..109, 50..59); mode 1: 5x5 block at (20..24, 10..14);
  // mode 2: hue wrap-around scene.
  function automatic logic [23:0] pix_hsv(input int mode, input int x, input int y);
    if (mode == 0) begin
      if (x >= 100 && x <= 109 && y >= 50 && y <= 59) return {8'd60, 8'd200, 8'd200};
      return {8'd120, 8'd200, 8'd200};
    end
    if (mode == 1) begin
      if (x >= 20 && x <= 24 && y >= 10 && y <= 14) return {8'd60, 8'd200, 8'd200};
      return {8'd120, 8'd200, 8'd200};
    end
    if (x >= 30 && x <= 37 && y >= 20 && y <= 27) return {8'd175, 8'd200, 8'd200};
    if (x == 10 && y == 25) return {8'd170, 8'd200, 8'd200};
    if (x == 60 && y == 28) return {8'd5,   8'd200, 8'd200};
    if (x == 80 && y == 40) return {8'd90,  8'd200, 8'd200};
    if (x == 90 && y == 45) return {8'd175, 8'd50,  8'd200};
    if (x == 95 && y == 46) return {8'd5,   8'd200, 8'd99};
    return {8'd90, 8'd0, 8'd0};
  endfunction

  function automatic bit on_border(input int x, input int y);
    return ((x == ex0 || x == ex1) && y >= ey0 && y <= ey1) ||
           ((y == ey0 || y == ey1) && x >= ex0 && x <= ex1);
  endfunction

  task automatic check_point();
    bit pix_pt, lat_pt;
    pix_pt = (h2_y == 55 && (h2_x == 100 || h2_x == 105 || h2_x == 110)) ||
             (h2_y == 50 && h2_x == 105) || (h2_y == 59 && h2_x == 109);
    lat_pt = (h2_y == 55 && (h2_x == W - 1 || h2_x == W));
    if (pix_pt || lat_pt) begin
      check($sformatf("post_hs@%0d,%0d", h2_x, h2_y), 32'(post_hs), 32'(h2_hs));
      check($sformatf("post_vs@%0d,%0d", h2_x, h2_y), 32'(post_vs), 32'(h2_vs));
      check($sformatf("post_clken@%0d,%0d", h2_x, h2_y), 32'(post_clken), 32'(h2_ck));
    end
    if (pix_pt)
      check($sformatf("post_rgb@%0d,%0d", h2_x, h2_y), 32'(post_rgb),
            32'((ev && on_border(h2_x, h2_y)) ? BOX : h2_rgb));
  endtask

  task automatic step(input logic hs, input logic vs, input logic ck,
                      input logic [23:0] rgb, input logic [23:0] hsv, input int x, input int y);
    @(negedge clk);
    check_point();
    h2_x = h1_x; h2_y = h1_y; h2_hs = h1_hs; h2_vs = h1_vs; h2_ck = h1_ck; h2_rgb = h1_rgb;
    h1_x = x;    h1_y = y;    h1_hs = hs;    h1_vs = vs;    h1_ck = ck;    h1_rgb = rgb;
    pre_hs = hs; pre_vs = vs; pre_clken = ck; pre_rgb = rgb; pre_hsv = hsv;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_post_hs"},    32'(post_hs),    32'd0);
    check({tag, "_post_vs"},    32'(post_vs),    32'd0);
    check({tag, "_post_clken"}, 32'(post_clken), 32'd0);
    check({tag, "_post_rgb"},   32'(post_rgb),   32'd0);
    check({tag, "_box_x0"},     32'(box_x0),     32'd0);
    check({tag, "_box_x1"},     32'(box_x1),     32'd0);
    check({tag, "_box_y0"},     32'(box_y0),     32'd0);
    check({tag, "_box_y1"},     32'(box_y1),     32'd0);
    check({tag, "_box_valid"},  32'(box_valid),  32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic check_box(input string tag);
    check({tag, "_box_x0"},    32'(box_x0),    32'(ex0));
    check({tag, "_box_x1"},    32'(box_x1),    32'(ex1));
    check({tag, "_box_y0"},    32'(box_y0),    32'(ey0));
    check({tag, "_box_y1"},    32'(box_y1),    32'(ey1));
    check({tag, "_box_valid"}, 32'(box_valid), 32'(ev));
  endtask

  task automatic wait_done(input int exp_n, input string tag);
    int cnt   = 0;
    int first = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check({tag, "_done_pulses"}, 32'(cnt), 32'(exp_n));
    if (exp_n > 0) check({tag, "_done_timing"}, 32'(first), 32'd0);
  endtask

  task automatic mid_reset(input string tag);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_zero(tag);
    rst = 1'b0;
    ex0 = 0; ex1 = 0; ey0 = 0; ey1 = 0; ev = 1'b0;
  endtask

  task automatic run_frame(input int mode, input int n_lines, input int rst_line);
    if (mode == 2) begin
      h_min = 8'd170; h_max = 8'd10; s_min = 8'd100; s_max = 8'd255; v_min = 8'd100; v_max = 8'd250;
    end else begin
      h_min = 8'd50;  h_max = 8'd70; s_min = 8'd100; s_max = 8'd255; v_min = 8'd100; v_max = 8'd255;
    end
    step(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, -1, -1);
    step(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, -1, -1);
    // Live thresholds go unusable after frame start; only the shadowed copy may be used.
    h_min = 8'd200; h_max = 8'd200; s_min = 8'd255; s_max = 8'd0; v_min = 8'd255; v_max = 8'd0;
    repeat (2) step(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, -1, -1);
    for (int y = 0; y < n_lines; y++) begin
      if (y == rst_line) mid_reset("midrst");
      for (int x = 0; x < W; x++)
        step(1'b1, 1'b1, 1'b1, rgb_of(x, y), pix_hsv(mode, x, y), x, y);
      for (int b = 0; b < BL; b++)
        step(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, W + b, y);
    end
    step(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, -1, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pre_hs = 1'b0; pre_vs = 1'b1; pre_clken = 1'b0; pre_rgb = '0; pre_hsv = '0;
    h_min = '0; h_max = '0; s_min = '0; s_max = '0; v_min = '0; v_max = '0;

    // Reset with pre_vs high, then a pre_vs fall that had no rise: must be ignored.
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (4) step(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, -1, -1);
    step(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, -1, -1);
    wait_done(0, "orphan_fall");
    check_zero("orphan_fall");

    // 10x10 block -> valid box.
    run_frame(0, 64, -1);
    wait_done(1, "block10");
    ex0 = 100; ex1 = 109; ey0 = 50; ey1 = 59; ev = 1'b1;
    check_box("block10");

    // 5x5 block below MIN_PIX, overlay of previous box checked along the way.
    run_frame(1, 64, -1);
    wait_done(1, "block5");
    ev = 1'b0;
    check_box("block5");

    // Hue wrap-around window 170..10.
    run_frame(2, 64, -1);
    wait_done(1, "hue_wrap");
    ex0 = 10; ex1 = 60; ey0 = 20; ey1 = 28; ev = 1'b1;
    check_box("hue_wrap");

    // Reset at line 200 of a matching frame; its pre_vs fall must be ignored.
    run_frame(0, 206, 200);
    wait_done(0, "after_midrst");
    check_box("after_midrst");

    // Next full frame latches normally again.
    run_frame(0, 64, -1);
    wait_done(1, "recover");
    ex0 = 100; ex1 = 109; ey0 = 50; ey1 = 59; ev = 1'b1;
    check_box("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
